uart_result_checker: RTL
========================

// Module: uart_result_checker
// PURPOSE
//  Synthesizable pass/fail monitor downstream of the CPU UART transmitter. Deserializes cpu serial_out (8N1),
//  hunts for the ASCII banner "Result: ", captures the following 8 lowercase hex digits as a 32-bit checksum,
//  compares it against the CPU CSR (tohost) value once that is non-zero, and drives sticky done/pass.
//  Enables self-checking benchmark runs on the FPGA (LEDs) and in simulation without a behavioural UART model.
// PARAMETERS
//  CLOCK_FREQ       50_000_000  clk frequency in Hz
//  BAUD_RATE        10_000_000  UART bit rate; SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (must be >= 4)
//  TIMEOUT_CYCLES   1_000_000   watchdog limit (used only with UART_CHECKER_TIMEOUT_EN)
// PORTS
//  clk          in   1   single clock
//  rst          in   1   synchronous, active-high reset
//  serial_in    in   1   UART line from cpu serial_out; idle high
//  csr_value    in   32  CPU CSR value; non-zero means the program has finished
//  rx_data      out  8   last received byte (valid with rx_valid)
//  rx_valid     out  1   one-cycle pulse per correctly framed byte
//  frame_err    out  1   one-cycle pulse: stop bit sampled low, byte dropped
//  hex_err      out  1   one-cycle pulse: non-hex char inside the 8-digit field
//  captured     out  32  checksum assembled from the hex digits (MSB digit first)
//  done         out  1   sticky: comparison made (or timeout)
//  pass         out  1   sticky: captured == csr_value at comparison; meaningful only when done
// BEHAVIOUR
//  Reset: all outputs 0, captured 0, FSMs idle; all registers update on posedge clk.
//  RX: serial_in passes a 2-flop synchronizer (2-cycle latency). After reset, start detection is armed only once
//   the synced line has been sampled high (no lock onto a frame already in flight).
//  RX start: synced low while idle -> count SYMBOL_EDGE_TIME/2; re-sample; high = glitch, return to idle.
//  RX data: 8 bits LSB first, each sampled SYMBOL_EDGE_TIME after the previous; then stop bit.
//   Stop=1 -> rx_data updated, rx_valid pulses the same cycle. Stop=0 -> frame_err pulse, rx_data unchanged.
//   After the stop sample, RX returns to idle immediately (next start bit detectable).
//  Parser states: HUNT, MATCH(idx 0..7), HEX(cnt 0..7), WAIT_CSR, DONE; advances only on rx_valid.
//   HUNT/MATCH: byte == banner[idx] -> idx+1; idx reaching 8 -> HEX with cnt=0 and captured cleared.
//   Mismatch: idx = (byte=='R') ? 1 : 0 (restart-on-R, covers "ResResult: ").
//   HEX: '0'-'9','a'-'f' -> captured = {captured[27:0], nibble}, cnt+1; after 8th digit -> WAIT_CSR.
//   Any other byte in HEX -> hex_err pulse, back to HUNT, captured keeps partial value.
//   WAIT_CSR: csr_value != 0 -> DONE, done=1, pass=(captured==csr_value), same cycle-edge.
//   csr_value becoming non-zero before capture completes: no effect until WAIT_CSR reached.
//   DONE: absorbing until rst; further bytes still reported on rx_* but ignored; captured frozen.
//  Reset asserted mid-frame or mid-parse: everything returns to reset state next edge; no partial byte survives.
// CONFIGURATION
//  UART_CHECKER_TIMEOUT_EN defined: 32-bit cycle counter from reset release; reaching TIMEOUT_CYCLES before
//   DONE forces DONE with done=1, pass=0; additional output timed_out (1 bit, sticky) is present.
//   A normal comparison on the same edge as the timeout wins (timed_out stays 0).
//  Not defined: no counter, no timed_out port; done asserts only via comparison.
// STRUCTURE
//  uart_checker_defs.vh: parser state encodings, BANNER ("Result: ") byte constants, ASCII '0','9','a','f'.
//  Sub-module uart_rx_sampler (synchronizer + bit-timing counter + shift reg) -> rx_data/rx_valid/frame_err;
//  uart_result_checker holds the parser FSM, hex accumulator, comparison and optional watchdog.
// TESTING (CLOCK_FREQ 50e6, BAUD_RATE 10e6 -> 5 clk/bit)
//  1 "Result: 1234abcd\n", then csr_value=32'h1234abcd -> captured=32'h1234abcd, done=1, pass=1.
//  2 Same string, csr_value=32'h1234abce -> done=1, pass=0; later csr change leaves pass=0.
//  3 "ResResult: 0000beef", csr=32'h0000beef -> pass=1; csr set before string -> done only after 8th digit.
//  4 Byte 8'h41 with stop bit driven 0 -> frame_err pulse, no rx_valid; next good byte received normally.
//  5 "Result: 12G" then "Result: cafef00d", csr=32'hcafef00d -> hex_err on 'G', then pass=1.
//  6 UART_CHECKER_TIMEOUT_EN, TIMEOUT_CYCLES=1000, line idle -> done=1, pass=0, timed_out=1 at cycle 1000.
//  Also: rst mid-byte then clean frame -> correct byte; 1-cycle low glitch on idle line -> no rx_valid.

Source files
------------

// File: rtl/uart_result_checker_pkg.sv
// Shared definitions for the UART result checker: parser and receiver state
// encodings, the "Result: " banner bytes and the ASCII hex-digit bounds.
package uart_result_checker_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_MATCH,
    ST_HEX,
    ST_WAIT_CSR,
    ST_DONE
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;
  localparam logic [7:0] ASCII_A = 8'h61;  // lowercase 'a'
  localparam logic [7:0] ASCII_F = 8'h66;  // lowercase 'f'
  localparam logic [7:0] ASCII_R = 8'h52;  // first banner character

  // Banner "Result: " indexed by match position
  function automatic logic [7:0] banner_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h52;  // R
      3'd1:    b = 8'h65;  // e
      3'd2:    b = 8'h73;  // s
      3'd3:    b = 8'h75;  // u
      3'd4:    b = 8'h6C;  // l
      3'd5:    b = 8'h74;  // t
      3'd6:    b = 8'h3A;  // :
      default: b = 8'h20;  // space
    endcase
    return b;
  endfunction

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= ASCII_0) && (b <= ASCII_9)) || ((b >= ASCII_A) && (b <= ASCII_F));
  endfunction

  // Only meaningful when is_hex(b); 'a' - 8'h57 == 10
  function automatic logic [3:0] hex_nibble(input logic [7:0] b);
    logic [7:0] d;
    if (b <= ASCII_9) d = b - ASCII_0;
    else              d = b - 8'h57;
    return d[3:0];
  endfunction

endpackage

// File: rtl/uart_result_checker_rx_sampler.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling counter and
// LSB-first shift register. Start detection is only armed after the
// synchronized line has been seen high following reset.
module uart_rx_sampler
  import uart_result_checker_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_TIME        = SYMBOL_EDGE_TIME / 2;
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME + 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TIME - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_armed;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  // Synchronizer stages; cleared low so a line stuck low across reset cannot arm the receiver
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= serial_in;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Receive FSM: start validation at half bit, then one sample per bit period
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RX_IDLE;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (r_sync_p1) r_armed <= 1'b1;
      case (r_state)
        RX_IDLE: begin
          if (r_armed && !r_sync_p1) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            // A line back high at mid start bit was a glitch
            r_state   <= r_sync_p1 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync_p1, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state   <= RX_STOP;
            else                   r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync_p1) begin
              rx_data  <= r_shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_result_checker.sv
// Pass/fail monitor on the CPU UART output: finds "Result: ", captures the
// following 8 lowercase hex digits and compares them with the CSR value once
// it becomes non-zero. Optional watchdog enabled by UART_CHECKER_TIMEOUT_EN,
// which also adds the sticky timed_out output.
module uart_result_checker
  import uart_result_checker_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 10_000_000
`ifdef UART_CHECKER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_in,
  input  logic [31:0] csr_value,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        hex_err,
  output logic [31:0] captured,
  output logic        done,
  output logic        pass
`ifdef UART_CHECKER_TIMEOUT_EN
  ,
  output logic        timed_out
`endif
);

  parse_state_t r_state;
  logic [2:0]   r_idx;
  logic [2:0]   r_cnt;
  logic         w_cmp_now;
`ifdef UART_CHECKER_TIMEOUT_EN
  logic [31:0]  r_tmo_cnt;
`endif

  uart_rx_sampler #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .serial_in(serial_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  assign w_cmp_now = (r_state == ST_WAIT_CSR) && (csr_value != '0);

  // Parser FSM: banner match, hex accumulation, comparison and optional watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_HUNT;
      r_idx    <= '0;
      r_cnt    <= '0;
      captured <= '0;
      hex_err  <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
`ifdef UART_CHECKER_TIMEOUT_EN
      r_tmo_cnt <= '0;
      timed_out <= 1'b0;
`endif
    end else begin
      hex_err <= 1'b0;
      case (r_state)
        ST_HUNT, ST_MATCH: begin
          if (rx_valid) begin
            if (rx_data == banner_byte(r_idx)) begin
              if (r_idx == 3'd7) begin
                r_state  <= ST_HEX;
                r_idx    <= '0;
                r_cnt    <= '0;
                captured <= '0;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= ST_MATCH;
              end
            end else if (rx_data == ASCII_R) begin
              // A stray 'R' may itself start the real banner ("ResResult: ")
              r_idx   <= 3'd1;
              r_state <= ST_MATCH;
            end else begin
              r_idx   <= '0;
              r_state <= ST_HUNT;
            end
          end
        end
        ST_HEX: begin
          if (rx_valid) begin
            if (is_hex(rx_data)) begin
              captured <= {captured[27:0], hex_nibble(rx_data)};
              if (r_cnt == 3'd7) r_state <= ST_WAIT_CSR;
              else               r_cnt   <= r_cnt + 1'b1;
            end else begin
              // Partial value is left visible in captured for debug
              hex_err <= 1'b1;
              r_idx   <= '0;
              r_state <= ST_HUNT;
            end
          end
        end
        ST_WAIT_CSR: begin
          if (w_cmp_now) begin
            r_state <= ST_DONE;
            done    <= 1'b1;
            pass    <= (captured == csr_value);
          end
        end
        ST_DONE: ;
        default: r_state <= ST_HUNT;
      endcase
`ifdef UART_CHECKER_TIMEOUT_EN
      // Watchdog; a comparison landing on the expiry edge takes precedence
      if (r_state != ST_DONE) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        if ((r_tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) && !w_cmp_now) begin
          r_state   <= ST_DONE;
          done      <= 1'b1;
          pass      <= 1'b0;
          timed_out <= 1'b1;
        end
      end
`endif
    end
  end

endmodule
